// File: rtl/exc_detect.sv
// Purpose : collect decode/memory faults and an external IRQ, pick one cause, drive Exc/EStatus.
// Latency : synchronous source to Exc is 1 cycle; ext_irq rise to Exc is SYNC_STAGES+2 cycles.
// Backpr. : Exc is held until ExcAck; new causes are dropped (IRQ stays pending) until ERet.
module exc_detect #(
    parameter int SYNC_STAGES = 2,  // ext_irq synchroniser depth, must be >= 2
    parameter int CNT_W       = 8   // width of the taken-exception counter
) (
    input  logic             clk,
    input  logic             reset,        // asynchronous, active-low
    input  logic             ext_irq,
    input  logic             irq_en,
    input  logic             invalid_op_D,
    input  logic             svc_D,
    input  logic             misalign_M,
    input  logic             ExcAck,
    input  logic             ERet,
    output logic             Exc,
    output logic [3:0]       EStatus,
    output logic             Flush,
    output logic             busy,
    output logic [CNT_W-1:0] exc_count
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;  // accepting new causes
    localparam logic [1:0] ST_PEND = 2'd1;  // Exc raised, waiting for ExcAck
    localparam logic [1:0] ST_SERV = 2'd2;  // handler running, waiting for ERet

    // Cause codes presented on EStatus
    localparam logic [3:0] CODE_NONE = 4'b0000;
    localparam logic [3:0] CODE_INV  = 4'b0001;
    localparam logic [3:0] CODE_IRQ  = 4'b0010;
    localparam logic [3:0] CODE_MIS  = 4'b0011;
    localparam logic [3:0] CODE_SVC  = 4'b0100;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Registered state
    logic [1:0]             state_q,       state_d;
    logic                   exc_q,         exc_d;
    logic [3:0]             estatus_q,     estatus_d;
    logic                   flush_q,       flush_d;
    logic                   busy_q,        busy_d;
    logic [CNT_W-1:0]       cnt_q,         cnt_d;
    logic                   irq_pending_q, irq_pending_d;
    logic [SYNC_STAGES-1:0] sync_q,        sync_d;
    logic                   irq_dly_q,     irq_dly_d;

    // Combinational helpers
    logic       irq_rise;
    logic       irq_req;
    logic       any_src;
    logic       win_is_irq;
    logic [3:0] win_code;
    logic       take_irq;

    // Synchroniser shift, delay flop and rising-edge detect on the synchronised IRQ
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], ext_irq};
        irq_dly_d = sync_q[SYNC_STAGES-1];
        irq_rise  = sync_q[SYNC_STAGES-1] & ~irq_dly_q;
    end

    // Fixed-priority select: misaligned > invalid opcode > SVC > enabled pending IRQ
    always_comb begin
        irq_req    = irq_pending_q & irq_en;
        any_src    = misalign_M | invalid_op_D | svc_D | irq_req;
        win_is_irq = 1'b0;
        win_code   = CODE_NONE;
        if (misalign_M) begin
            win_code = CODE_MIS;
        end else if (invalid_op_D) begin
            win_code = CODE_INV;
        end else if (svc_D) begin
            win_code = CODE_SVC;
        end else if (irq_req) begin
            win_code   = CODE_IRQ;
            win_is_irq = 1'b1;
        end
    end

    // Sticky IRQ: cleared only when taken from IDLE; a fresh edge on that cycle wins
    always_comb begin
        take_irq      = (state_q == ST_IDLE) & win_is_irq;
        irq_pending_d = irq_rise | (irq_pending_q & ~take_irq);
    end

    // Exception FSM and output next-state; synchronous causes outside IDLE are dropped
    always_comb begin
        state_d   = state_q;
        exc_d     = exc_q;
        estatus_d = estatus_q;
        flush_d   = 1'b0;
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (any_src) begin
                    state_d   = ST_PEND;
                    exc_d     = 1'b1;
                    estatus_d = win_code;
                    flush_d   = 1'b1;
                    busy_d    = 1'b1;
                    if (!(&cnt_q)) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            ST_PEND: begin
                // ExcAck takes precedence; a coincident ERet is ignored
                if (ExcAck) begin
                    state_d = ST_SERV;
                    exc_d   = 1'b0;
                end
            end
            ST_SERV: begin
                if (ERet) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                exc_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            exc_q         <= 1'b0;
            estatus_q     <= CODE_NONE;
            flush_q       <= 1'b0;
            busy_q        <= 1'b0;
            cnt_q         <= '0;
            irq_pending_q <= 1'b0;
            sync_q        <= '0;
            irq_dly_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            exc_q         <= exc_d;
            estatus_q     <= estatus_d;
            flush_q       <= flush_d;
            busy_q        <= busy_d;
            cnt_q         <= cnt_d;
            irq_pending_q <= irq_pending_d;
            sync_q        <= sync_d;
            irq_dly_q     <= irq_dly_d;
        end
    end

    // All outputs come straight from flops
    assign Exc       = exc_q;
    assign EStatus   = estatus_q;
    assign Flush     = flush_q;
    assign busy      = busy_q;
    assign exc_count = cnt_q;

`ifndef SYNTHESIS
    // Flush only accompanies a freshly raised request
    a_flush_with_exc: assert property (@(posedge clk) disable iff (!reset) flush_q |-> exc_q);
    // A raised request always means the block is busy
    a_exc_busy:       assert property (@(posedge clk) disable iff (!reset) exc_q |-> busy_q);
    // Reserved cause codes never appear
    a_code_legal:     assert property (@(posedge clk) disable iff (!reset) estatus_q <= CODE_SVC);
`endif

endmodule

// File: tb/tb_exc_detect.sv
// Purpose : directed self-checking bench for exc_detect.
// Latency : inputs driven 1 time unit after the rising edge, outputs sampled there too.
// Backpr. : ExcAck/ERet are driven explicitly by the stimulus sequence.
module tb_exc_detect;

    logic       clk;
    logic       reset;
    logic       ext_irq;
    logic       irq_en;
    logic       invalid_op_D;
    logic       svc_D;
    logic       misalign_M;
    logic       ExcAck;
    logic       ERet;
    logic       Exc;
    logic [3:0] EStatus;
    logic       Flush;
    logic       busy;
    logic [7:0] exc_count;

    int n_cmp = 0;
    int n_err = 0;

    exc_detect #(.SYNC_STAGES(2), .CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .ext_irq      (ext_irq),
        .irq_en       (irq_en),
        .invalid_op_D (invalid_op_D),
        .svc_D        (svc_D),
        .misalign_M   (misalign_M),
        .ExcAck       (ExcAck),
        .ERet         (ERet),
        .Exc          (Exc),
        .EStatus      (EStatus),
        .Flush        (Flush),
        .busy         (busy),
        .exc_count    (exc_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one rising edge, then settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ext_irq      = 1'b0;
        irq_en       = 1'b1;
        invalid_op_D = 1'b0;
        svc_D        = 1'b0;
        misalign_M   = 1'b0;
        ExcAck       = 1'b0;
        ERet         = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    // acknowledge then return from handler
    task automatic ack_and_return();
        ExcAck = 1'b1;
        step();
        ExcAck = 1'b0;
        ERet   = 1'b1;
        step();
        ERet   = 1'b0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;
        #1;

        // ---------------- reset state ----------------
        step();
        step();
        chk("rst_exc",   Exc,       0);
        chk("rst_code",  EStatus,   0);
        chk("rst_flush", Flush,     0);
        chk("rst_busy",  busy,      0);
        chk("rst_cnt",   exc_count, 0);
        reset = 1'b1;
        step();
        chk("idle_exc", Exc, 0);

        // ---------------- single invalid opcode ----------------
        invalid_op_D = 1'b1;
        step();
        invalid_op_D = 1'b0;
        chk("inv_exc",   Exc,       1);
        chk("inv_code",  EStatus,   4'b0001);
        chk("inv_flush", Flush,     1);
        chk("inv_busy",  busy,      1);
        chk("inv_cnt",   exc_count, 1);
        step();
        chk("inv_flush_1cyc", Flush, 0);
        chk("inv_exc_hold",   Exc,   1);
        step();
        chk("inv_exc_hold2", Exc, 1);
        ExcAck = 1'b1;
        step();
        ExcAck = 1'b0;
        chk("inv_ack_exc",  Exc,     0);
        chk("inv_ack_busy", busy,    1);
        chk("inv_ack_code", EStatus, 4'b0001);
        step();
        chk("inv_serv_busy", busy, 1);
        ERet = 1'b1;
        step();
        ERet = 1'b0;
        chk("inv_eret_busy", busy, 0);
        chk("inv_eret_exc",  Exc,  0);

        // ---------------- priority, sources held into PEND are dropped ----------------
        do_reset();
        misalign_M   = 1'b1;
        invalid_op_D = 1'b1;
        svc_D        = 1'b1;
        step();
        chk("pri_code", EStatus, 4'b0011);
        chk("pri_exc",  Exc,     1);
        step();
        misalign_M   = 1'b0;
        invalid_op_D = 1'b0;
        svc_D        = 1'b0;
        ack_and_return();
        chk("pri_ret_busy", busy, 0);
        step();
        step();
        chk("pri_no_more_exc", Exc,       0);
        chk("pri_cnt",         exc_count, 1);

        // ---------------- IRQ latency ----------------
        do_reset();
        irq_en  = 1'b1;
        ext_irq = 1'b1;
        step();
        chk("irq_lat_e1", Exc, 0);
        step();
        chk("irq_lat_e2", Exc, 0);
        step();
        chk("irq_lat_e3", Exc, 0);
        step();
        chk("irq_lat_e4_exc",  Exc,     1);
        chk("irq_lat_e4_code", EStatus, 4'b0010);
        ack_and_return();
        ext_irq = 1'b0;
        step();
        step();
        step();
        step();
        chk("irq_taken_once", Exc,       0);
        chk("irq_cnt",        exc_count, 1);

        // ---------------- IRQ masked, then enabled ----------------
        do_reset();
        irq_en  = 1'b0;
        ext_irq = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("irq_mask_exc",  Exc,  0);
        chk("irq_mask_busy", busy, 0);
        irq_en = 1'b1;
        step();
        chk("irq_unmask_exc",  Exc,     1);
        chk("irq_unmask_code", EStatus, 4'b0010);
        ack_and_return();
        ext_irq = 1'b0;

        // ---------------- IRQ arriving while in service ----------------
        do_reset();
        svc_D = 1'b1;
        step();
        svc_D = 1'b0;
        chk("svc_code", EStatus, 4'b0100);
        ExcAck = 1'b1;
        step();
        ExcAck  = 1'b0;
        ext_irq = 1'b1;
        step();
        ext_irq = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("serv_irq_exc",  Exc,  0);
        chk("serv_irq_busy", busy, 1);
        ERet = 1'b1;
        step();
        ERet = 1'b0;
        chk("serv_ret_idle_busy", busy, 0);
        chk("serv_ret_idle_exc",  Exc,  0);
        step();
        chk("serv_irq_taken", Exc,       1);
        chk("serv_irq_code",  EStatus,   4'b0010);
        chk("serv_irq_cnt",   exc_count, 2);

        // ---------------- ExcAck and ERet together in PEND ----------------
        do_reset();
        invalid_op_D = 1'b1;
        step();
        invalid_op_D = 1'b0;
        ExcAck = 1'b1;
        ERet   = 1'b1;
        step();
        ExcAck = 1'b0;
        ERet   = 1'b0;
        chk("ackret_exc",  Exc,  0);
        chk("ackret_busy", busy, 1);
        ERet = 1'b1;
        step();
        ERet = 1'b0;
        chk("ackret_then_ret_busy", busy, 0);

        // ---------------- asynchronous reset mid-PEND ----------------
        do_reset();
        invalid_op_D = 1'b1;
        step();
        invalid_op_D = 1'b0;
        chk("arst_pre_exc", Exc, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_exc",   Exc,       0);
        chk("arst_code",  EStatus,   0);
        chk("arst_busy",  busy,      0);
        chk("arst_flush", Flush,     0);
        chk("arst_cnt",   exc_count, 0);
        step();
        reset = 1'b1;

        // ---------------- counter saturation ----------------
        do_reset();
        for (int i = 0; i < 260; i++) begin
            svc_D = 1'b1;
            step();
            svc_D = 1'b0;
            ack_and_return();
            if (i == 253) chk("cnt_254", exc_count, 254);
        end
        chk("cnt_sat", exc_count, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
